conv_sequencer: RTL
===================

// Module: conv_sequencer
// PURPOSE
//  Frame-level controller for the 8x8 -> 6x6 2D convolution engine. Accepts a streamed 8x8 signed-pixel
//  frame into the external pixel RAM, holds a 3x3 signed kernel, then walks all 6x6 window positions,
//  addressing the RAM tap-by-tap and accumulating in a MAC. Emits each result on a valid/ready stream
//  and pulses out_st when the frame is done. Sits between the frame source, the pixel RAM and the result sink.
// PARAMETERS
//  IMG_N  8   image side (pixels); OUT_N = IMG_N-K+1 is derived
//  K      3   kernel side; taps = K*K
//  DW     8   signed pixel / coefficient width
//  ACC_W  20  signed accumulator width (must hold K*K*2^(2*DW-2))
//  OUT_W  16  signed result width on res_data
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_st      in   1      frame start pulse; accepted only in IDLE
//  coef_we    in   1      kernel write strobe; honoured only in IDLE
//  coef_addr  in   4      kernel tap index 0..8 (row-major); 9..15 ignored
//  coef_data  in   DW     signed coefficient
//  pix_valid  in   1      pixel stream valid
//  pix_ready  out  1      high only in LOAD
//  pix_data   in   DW     signed pixel, row-major order
//  mem_we     out  1      pixel RAM write enable
//  mem_addr   out  6      pixel RAM address (shared write/read)
//  mem_wdata  out  DW     pixel RAM write data
//  mem_rdata  in   DW     pixel RAM read data, 1-cycle latency after mem_addr
//  res_valid  out  1      result valid; held until res_ready
//  res_ready  in   1      sink ready
//  res_data   out  OUT_W  signed result
//  res_row    out  3      window row 0..5;  res_col out 3: window col 0..5
//  out_st     out  1      one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset: state=IDLE; pix_ready, mem_we, res_valid, out_st = 0; mem_addr, mem_wdata, res_data, res_row,
//   res_col = 0; kernel registers = 0. Pixel RAM contents untouched. Reset mid-frame aborts to IDLE.
//  FSM: IDLE -(in_st)-> LOAD -(64th pixel accepted)-> CONV -(9 taps issued)-> FLUSH -> RESULT
//   -(res_valid&res_ready, not last window)-> CONV; (last window) -> DONE -> IDLE (out_st=1 in DONE).
//  IDLE: coef_we writes kernel[coef_addr]; in_st ignored in all other states; coef_we ignored outside IDLE.
//  LOAD: pix_ready=1; each pix_valid&pix_ready beat -> mem_we=1, mem_addr=count, mem_wdata=pix_data same
//   cycle; count 0..63, no gaps required; pix_valid low stalls without penalty.
//  CONV: window (r,c) row-major 0..35; tap t=0..8 issues mem_addr=(r+t/3)*8+(c+t%3) on cycles 0..8;
//   accumulator cleared at cycle 1 load, acc += mem_rdata*kernel[t] on cycles 1..9 (tap aligned by 1-cycle delay).
//  FLUSH = cycle 9 (last MAC); res_valid rises cycle 10 with res_row=r, res_col=c. Min 11 cycles/window.
//  RESULT: res_data/res_row/res_col stable while res_valid&!res_ready; next window starts cycle after handshake.
//  Arithmetic: products DW x DW signed -> 2*DW; sum sign-extended to ACC_W; never wraps in ACC_W.
//  DONE: out_st high exactly one cycle, one cycle after final handshake; returns to IDLE next cycle.
// CONFIGURATION
//  CONV_SAT_EN defined: res_data = acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  CONV_SAT_EN undefined: res_data = acc[OUT_W-1:0] (two's-complement truncation).
// STRUCTURE
//  conv_pkg: IMG_N, K, OUT_N, TAPS, DW/ACC_W/OUT_W constants; state_t enum
//   {IDLE,LOAD,CONV,FLUSH,RESULT,DONE}; addr/tap/window index typedefs.
//  Sub-module conv_mac: clr/en/pixel/coef in, ACC_W accumulator out, holds the CONV_SAT_EN output stage.
// TESTING
//  1. Kernel all 1, frame all 1 -> 36 results of 9, row-major (0,0)..(5,5), then single out_st pulse.
//  2. Kernel centre=1 else 0, pixel[a]=a -> result(r,c)=(r+1)*8+(c+1); e.g. (0,0)=9, (5,5)=54.
//  3. Kernel all 127, frame all 127 -> acc 145161; CONV_SAT_EN: 32767; without: 14089.
//  4. Kernel all -128, frame all 127 -> acc -146304; CONV_SAT_EN: -32768; without: -15232.
//  5. res_ready low 5 cycles on window 7 -> res_data/row/col stable, mem_addr frozen, no lost result.
//  6. reset mid-CONV window 20 -> all outputs 0 next cycle; new in_st + frame gives correct 36 results;
//     in_st/coef_we during LOAD -> ignored, kernel unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the 8x8 -> 6x6 convolution sequencer.
//   Geometry (IMG_N, K, OUT_N, TAPS), datapath widths (DW, ACC_W, OUT_W),
//   FSM state codes and the index typedefs used by the sequencer, its bus
//   interface and the MAC. tap_addr() maps (window row, window col, tap) to
//   a pixel RAM address.
package conv_pkg;
  localparam int IMG_N = 8;
  localparam int K     = 3;
  localparam int OUT_N = IMG_N - K + 1;
  localparam int TAPS  = K * K;
  localparam int DW    = 8;
  localparam int ACC_W = 20;
  localparam int OUT_W = 16;
  localparam int AW    = $clog2(IMG_N * IMG_N);

  typedef logic [2:0]    state_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [3:0]    tap_t;
  typedef logic [2:0]    win_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_CONV   = 3'd2;
  localparam state_t ST_FLUSH  = 3'd3;
  localparam state_t ST_RESULT = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Row-major pixel address of tap t of the window anchored at (r, c).
  function automatic addr_t tap_addr(win_t r, win_t c, tap_t t);
    int a;
    a = (int'(r) + int'(t) / K) * IMG_N + int'(c) + int'(t) % K;
    return addr_t'(a);
  endfunction
endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: all non-clock/reset signals of the convolution sequencer.
//   Control : in_st, coef_we/coef_addr/coef_data, out_st
//   Pixels  : pix_valid/pix_ready/pix_data stream in
//   RAM     : mem_we/mem_addr/mem_wdata out, mem_rdata in (1-cycle read latency)
//   Results : res_valid/res_ready/res_data/res_row/res_col stream out
// Modport slave is the sequencer's view; master is the environment's view.
interface conv_sequencer_if;
  import conv_pkg::*;

  logic                    in_st;
  logic                    coef_we;
  logic [3:0]              coef_addr;
  logic signed [DW-1:0]    coef_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic signed [DW-1:0]    pix_data;
  logic                    mem_we;
  addr_t                   mem_addr;
  logic signed [DW-1:0]    mem_wdata;
  logic signed [DW-1:0]    mem_rdata;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [OUT_W-1:0] res_data;
  win_t                    res_row;
  win_t                    res_col;
  logic                    out_st;

  modport slave (
    input  in_st, coef_we, coef_addr, coef_data, pix_valid, pix_data,
           mem_rdata, res_ready,
    output pix_ready, mem_we, mem_addr, mem_wdata, res_valid, res_data,
           res_row, res_col, out_st
  );

  modport master (
    output in_st, coef_we, coef_addr, coef_data, pix_valid, pix_data,
           mem_rdata, res_ready,
    input  pix_ready, mem_we, mem_addr, mem_wdata, res_valid, res_data,
           res_row, res_col, out_st
  );
endinterface

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate for one convolution window.
//   clk, reset : clock, synchronous active-high reset (acc -> 0)
//   clr        : with en, start a new sum from this product
//   en         : accumulate pix*coef this cycle
//   pix, coef  : DW-bit signed operands
//   res        : OUT_W-bit result derived from the ACC_W accumulator
// Macro CONV_SAT_EN: when defined res clamps to the OUT_W signed range,
// otherwise res is the two's-complement truncation of the accumulator.
module conv_mac
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    pix,
  input  logic signed [DW-1:0]    coef,
  output logic signed [OUT_W-1:0] res
);
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_x, base, acc_d, acc_q;

  always_comb begin
    prod   = pix * coef;
    prod_x = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    base   = clr ? '0 : acc_q;
    acc_d  = acc_q;
    if (en) acc_d = base + prod_x;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(OUT_W-1)));

  always_comb begin
    if (acc_q > SAT_HI)      res = SAT_HI[OUT_W-1:0];
    else if (acc_q < SAT_LO) res = SAT_LO[OUT_W-1:0];
    else                     res = acc_q[OUT_W-1:0];
  end
`else
  assign res = acc_q[OUT_W-1:0];
`endif
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: frame controller for the 8x8 -> 6x6 3x3 convolution engine.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, aborts any frame to IDLE
//   bus   : conv_sequencer_if.slave (kernel writes, pixel stream in, pixel
//           RAM port, result stream out, out_st frame-done pulse)
// Flow: IDLE (kernel writes, wait in_st) -> LOAD (64 pixels into RAM) ->
// per window CONV (9 tap reads) -> FLUSH (last MAC) -> RESULT (hold until
// accepted) ... -> DONE (out_st) -> IDLE.
// Macro CONV_SAT_EN (handled in conv_mac) selects saturating results.
module conv_sequencer
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  conv_sequencer_if.slave  bus
);
  localparam addr_t LAST_PIX = addr_t'(IMG_N * IMG_N - 1);
  localparam tap_t  LAST_TAP = tap_t'(TAPS - 1);
  localparam win_t  LAST_IDX = win_t'(OUT_N - 1);

  state_t state_q, state_d;
  addr_t  cnt_q, cnt_d;
  tap_t   tap_q, tap_d;
  win_t   row_q, row_d, col_q, col_d;
  logic   mac_en_q, mac_en_d;
  tap_t   mac_tap_q, mac_tap_d;
  logic signed [DW-1:0] kern_q [TAPS];
  logic signed [DW-1:0] kern_d [TAPS];

  logic pix_beat, last_win;

  assign pix_beat = (state_q == ST_LOAD) && bus.pix_valid;
  assign last_win = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: if (bus.in_st) begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        tap_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
      ST_LOAD: if (pix_beat) begin
        cnt_d = cnt_q + addr_t'(1);
        if (cnt_q == LAST_PIX) state_d = ST_CONV;
      end
      ST_CONV: begin
        tap_d = tap_q + tap_t'(1);
        if (tap_q == LAST_TAP) begin
          tap_d   = '0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_RESULT;
      ST_RESULT: if (bus.res_ready) begin
        if (last_win) state_d = ST_DONE;
        else begin
          state_d = ST_CONV;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + win_t'(1);
          end else begin
            col_d = col_q + win_t'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Kernel is writable only while idle; taps beyond 8 are dropped.
  always_comb begin
    kern_d = kern_q;
    if (state_q == ST_IDLE && bus.coef_we && bus.coef_addr <= LAST_TAP)
      kern_d[bus.coef_addr] = bus.coef_data;
  end

  // RAM data for a tap lands one cycle after its address, so the MAC
  // control (enable and tap index) is the CONV issue info delayed by one.
  always_comb begin
    mac_en_d  = (state_q == ST_CONV);
    mac_tap_d = tap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tap_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mac_en_q  <= 1'b0;
      mac_tap_q <= '0;
      for (int i = 0; i < TAPS; i++) kern_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mac_en_q  <= mac_en_d;
      mac_tap_q <= mac_tap_d;
      kern_q    <= kern_d;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == ST_LOAD) begin
      bus.mem_addr = cnt_q;
      if (pix_beat) bus.mem_wdata = bus.pix_data;
    end else if (state_q == ST_CONV) begin
      bus.mem_addr = tap_addr(row_q, col_q, tap_q);
    end
  end

  assign bus.pix_ready = (state_q == ST_LOAD);
  assign bus.mem_we    = pix_beat;
  assign bus.res_valid = (state_q == ST_RESULT);
  assign bus.res_row   = row_q;
  assign bus.res_col   = col_q;
  assign bus.out_st    = (state_q == ST_DONE);

  conv_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_tap_q == '0),
    .en    (mac_en_q),
    .pix   (bus.mem_rdata),
    .coef  (kern_q[mac_tap_q]),
    .res   (bus.res_data)
  );
endmodule
